// File: rtl/ni_packet_injector_if.sv
// rtl/ni_packet_injector_if.sv - PE request and router channel signals of the packet injector
interface ni_packet_injector_if #(
  parameter int ADDR_FIELD    = 3,
  parameter int FLIT_WIDTH    = 32,
  parameter int PAYLOAD_FLITS = 3
);
  logic                                req_valid_din;
  logic                                req_ready_dout;
  logic [ADDR_FIELD-1:0]               x_dest_din;
  logic [ADDR_FIELD-1:0]               y_dest_din;
  logic                                done_din;
  logic [PAYLOAD_FLITS*FLIT_WIDTH-1:0] payload_din;
  logic [FLIT_WIDTH-1:0]               channel_dout;
  logic                                channel_valid_dout;
  logic                                channel_tail_dout;
  logic                                credit_din;
  logic                                credit_error_dout;
  logic [7:0]                          seq_dout;

  modport slave (
    input  req_valid_din, x_dest_din, y_dest_din, done_din, payload_din, credit_din,
    output req_ready_dout, channel_dout, channel_valid_dout, channel_tail_dout,
           credit_error_dout, seq_dout
  );

  modport master (
    output req_valid_din, x_dest_din, y_dest_din, done_din, payload_din, credit_din,
    input  req_ready_dout, channel_dout, channel_valid_dout, channel_tail_dout,
           credit_error_dout, seq_dout
  );
endinterface

// File: rtl/ni_packet_injector.sv
// rtl/ni_packet_injector.sv - credit-flow-controlled header+payload flit serialiser for the router PE port
module ni_packet_injector #(
  parameter int X_LOCAL       = 2,
  parameter int Y_LOCAL       = 2,
  parameter int ADDR_FIELD    = 3,
  parameter int FLIT_WIDTH    = 32,
  parameter int PAYLOAD_FLITS = 3,
  parameter int CREDITS       = 4
) (
  input logic                  clk,
  input logic                  reset,
  ni_packet_injector_if.slave  bus
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam int IW = $clog2(PAYLOAD_FLITS + 1);
  localparam int HW = 1 + 4 * ADDR_FIELD;
  localparam logic [CW-1:0]         CREDITS_FULL = CW'(CREDITS);
  localparam logic [IW-1:0]         LAST_IDX     = IW'(PAYLOAD_FLITS - 1);
  localparam logic [ADDR_FIELD-1:0] XL           = ADDR_FIELD'(X_LOCAL);
  localparam logic [ADDR_FIELD-1:0] YL           = ADDR_FIELD'(Y_LOCAL);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                              state;
  logic [CW-1:0]                       credits;
  logic [7:0]                          seq;
  logic [7:0]                          seq_l;
  logic [IW-1:0]                       idx;
  logic                                done_l;
  logic [ADDR_FIELD-1:0]               x_l;
  logic [ADDR_FIELD-1:0]               y_l;
  logic [PAYLOAD_FLITS*FLIT_WIDTH-1:0] payload_l;
  logic [FLIT_WIDTH-1:0]               header;
  logic                                send;
  logic                                last;

  assign send = (state != IDLE) && (credits != '0);
  assign last = (idx == LAST_IDX);
  assign bus.seq_dout = seq;

  // Route fields are packed at the top of the flit; the sequence number sits in the low byte.
  always_comb begin
    header = '0;
    header[7:0] = seq_l;
    header[FLIT_WIDTH-1 -: HW] = {done_l, x_l, y_l, XL, YL};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      credits               <= CREDITS_FULL;
      seq                   <= '0;
      seq_l                 <= '0;
      idx                   <= '0;
      done_l                <= 1'b0;
      x_l                   <= '0;
      y_l                   <= '0;
      payload_l             <= '0;
      bus.req_ready_dout    <= 1'b1;
      bus.channel_dout      <= '0;
      bus.channel_valid_dout <= 1'b0;
      bus.channel_tail_dout <= 1'b0;
      bus.credit_error_dout <= 1'b0;
    end else begin
      bus.channel_valid_dout <= send;
      bus.channel_tail_dout  <= send && (state == PAYLOAD) && last;
      if (send) begin
        bus.channel_dout <= (state == HEADER) ? header
                                              : payload_l[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH];
      end

      // A returned credit and a sent flit in the same cycle cancel out.
      if (send && !bus.credit_din) begin
        credits <= credits - 1'b1;
      end else if (!send && bus.credit_din) begin
        if (credits == CREDITS_FULL) bus.credit_error_dout <= 1'b1;
        else                         credits <= credits + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.req_valid_din && bus.req_ready_dout) begin
            done_l             <= bus.done_din;
            x_l                <= bus.x_dest_din;
            y_l                <= bus.y_dest_din;
            payload_l          <= bus.payload_din;
            seq_l              <= seq;
            seq                <= seq + 8'd1;
            bus.req_ready_dout <= 1'b0;
            state              <= HEADER;
          end
        end
        HEADER: begin
          if (send) begin
            idx   <= '0;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (send) begin
            if (last) begin
              bus.req_ready_dout <= 1'b1;
              state              <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ni_packet_injector.sv
// tb/tb_ni_packet_injector.sv - randomized self-checking bench against a flit-queue reference model
module tb_ni_packet_injector;
  localparam int CREDITS = 4;
  localparam int PF      = 3;
  localparam int FW      = 32;
  localparam int AF      = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ni_packet_injector_if #(.ADDR_FIELD(AF), .FLIT_WIDTH(FW), .PAYLOAD_FLITS(PF)) bus ();

  ni_packet_injector #(
    .X_LOCAL(2), .Y_LOCAL(2), .ADDR_FIELD(AF), .FLIT_WIDTH(FW),
    .PAYLOAD_FLITS(PF), .CREDITS(CREDITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: flits still owed for the accepted packet, credit count, sticky error, next seq.
  logic [FW-1:0] exp_q[$];
  int            m_credits;
  bit            m_err;
  int            m_seq;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_credits = CREDITS;
    m_err     = 1'b0;
    m_seq     = 0;
  endtask

  task automatic set_fields();
    bus.x_dest_din  = AF'($urandom);
    bus.y_dest_din  = AF'($urandom);
    bus.done_din    = 1'($urandom);
    bus.payload_din = {$urandom, $urandom, $urandom};
  endtask

  task automatic step(input bit req, input bit cred);
    bit snd;
    bit acc;
    bus.req_valid_din = req;
    bus.credit_din    = cred;
    @(posedge clk);
    snd = (exp_q.size() != 0) && (m_credits > 0);
    acc = req && (exp_q.size() == 0);
    #1;
    check("valid", bus.channel_valid_dout, snd);
    check("tail", bus.channel_tail_dout, snd && (exp_q.size() == 1));
    if (snd) begin
      check("flit", bus.channel_dout, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (snd && !cred) m_credits--;
    else if (!snd && cred) begin
      if (m_credits == CREDITS) m_err = 1'b1;
      else m_credits++;
    end
    if (acc) begin
      exp_q.push_back({bus.done_din, bus.x_dest_din, bus.y_dest_din, 3'd2, 3'd2, 11'd0, m_seq[7:0]});
      for (int i = 0; i < PF; i++) exp_q.push_back(bus.payload_din[i*FW +: FW]);
      m_seq = (m_seq + 1) % 256;
    end
    check("ready", bus.req_ready_dout, exp_q.size() == 0);
    check("credits", dut.credits, m_credits);
    check("cred_err", bus.credit_error_dout, m_err);
    check("seq", bus.seq_dout, m_seq);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_valid", bus.channel_valid_dout, 0);
    check("rst_tail", bus.channel_tail_dout, 0);
    check("rst_ready", bus.req_ready_dout, 1);
    check("rst_credits", dut.credits, CREDITS);
    check("rst_seq", bus.seq_dout, 0);
    check("rst_err", bus.credit_error_dout, 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset             = 1'b0;
    bus.req_valid_din = 1'b0;
    bus.credit_din    = 1'b0;
    bus.x_dest_din    = '0;
    bus.y_dest_din    = '0;
    bus.done_din      = 1'b0;
    bus.payload_din   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", bus.channel_dout, 0);
    check("rst_valid", bus.channel_valid_dout, 0);
    check("rst_ready", bus.req_ready_dout, 1);
    check("rst_credits", dut.credits, CREDITS);
    check("rst_seq", bus.seq_dout, 0);
    check("rst_err", bus.credit_error_dout, 0);
    reset = 1'b1;

    // Basic packet to (5,1)
    set_fields();
    bus.x_dest_din = 3'd5;
    bus.y_dest_din = 3'd1;
    bus.done_din   = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("t1_header", bus.channel_dout, 32'h5290_0000);
    repeat (3) step(1'b0, 1'b0);
    check("t1_credits", dut.credits, 0);
    check("t1_seq", bus.seq_dout, 1);

    // Stall with no credits, then release one flit per returned credit
    set_fields();
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    repeat (PF + 1) begin
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
    end
    check("t2_ready", bus.req_ready_dout, 1);

    // Credit returned on every send cycle keeps the count full
    repeat (CREDITS) step(1'b0, 1'b1);
    set_fields();
    step(1'b1, 1'b0);
    repeat (PF + 1) begin
      step(1'b0, 1'b1);
      check("t3_credits", dut.credits, CREDITS);
    end
    step(1'b0, 1'b0);

    // Reset after payload flit 0, then a full clean packet
    set_fields();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    pulse_reset();
    set_fields();
    step(1'b1, 1'b0);
    repeat (PF + 2) step(1'b0, 1'b0);

    // Credit overflow while idle is sticky
    repeat (CREDITS) step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("t4_err", bus.credit_error_dout, 1);
    repeat (3) step(1'b0, 1'b0);
    check("t4_err_sticky", bus.credit_error_dout, 1);
    check("t4_credits", dut.credits, CREDITS);

    // 257 back-to-back packets: seq wraps to 0 on the last
    pulse_reset();
    repeat (257 * (PF + 2)) begin
      set_fields();
      step(1'b1, 1'b1);
    end
    repeat (PF + 2) step(1'b0, 1'b1);
    check("t6_seq_wrap", bus.seq_dout, 1);

    // Randomized traffic and credit returns
    for (int n = 0; n < 3000; n++) begin
      set_fields();
      step($urandom_range(0, 3) != 0, 1'($urandom));
    end
    repeat (20) step(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
